tcb_lib_register_backpressure_fifo: RTL and testbench
=====================================================

Name: tcb_lib_register_backpressure_fifo

Overview:
Parametrised successor to the single-stage TCB backpressure register slice. It inserts a DEPTH-entry request FIFO between a TCB subordinate port and a TCB manager port, so the sub-side ready comes from a register and never depends combinationally on man_rdy. Because buffering makes the request-to-response latency variable, it also returns man-side responses in order on the sub side, tagged with an explicit response-valid strobe. It sits between bus managers and the interconnect or memory wherever the rdy timing path must be cut.

Parameters:
DLY, 1, man-side response delay in cycles after the man-side handshake (0 allowed)
ADR, 32, address width
DAT, 32, data width (multiple of 8)
DEPTH, 2, request FIFO entries (>=1, need not be a power of two)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-low
sub_vld  input  1  request valid from upstream manager
sub_rdy  output  1  request ready; registered
sub_wen  input  1  write enable
sub_adr  input  ADR  address
sub_ben  input  DAT/8  byte enables
sub_wdt  input  DAT  write data
sub_rsp  output  1  response valid strobe
sub_rdt  output  DAT  read data
sub_err  output  1  error response
man_vld  output  1  request valid to downstream
man_rdy  input  1  downstream ready
man_wen  output  1  write enable
man_adr  output  ADR  address
man_ben  output  DAT/8  byte enables
man_wdt  output  DAT  write data
man_rdt  input  DAT  read data
man_err  input  1  error response

Behaviour:
- Reset (rst=0, asynchronous): clear the FIFO, pointers, count and response pipeline. Output reset values are sub_rdy=0, man_vld=0, man_wen/adr/ben/wdt=0, sub_rsp=0, sub_rdt=0, sub_err=0. sub_rdy rises on the first clk edge after reset is released.
- Storage: DEPTH entries of {wen, adr, ben, wdt}. The count register is $clog2(DEPTH+1) bits wide. Read and write pointers wrap from DEPTH-1 to 0.
- Push: sub_vld & sub_rdy. Pop: man_vld & man_rdy.
- sub_rdy: registered. Next value is (count_next < DEPTH). There is no same-cycle pop lookahead, so a full FIFO does not accept a request even while it pops.
- Throughput: DEPTH=1 alternates, giving at most 1 transfer every 2 cycles. DEPTH>=2 sustains 1 transfer per cycle.
- man_vld = (count != 0). The man payload comes from the head entry only; there is no combinational path from sub to man.
- Request latency: push at cycle t gives man_vld no earlier than t+1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Response pipeline: DLY+1 valid bits shifted every cycle.
  - A pop at cycle t marks man_rdt/man_err for sampling at t+DLY (the same cycle when DLY=0).
  - The sampled value is registered onto sub_rdt/sub_err with sub_rsp=1 at t+DLY+1.
  - When sub_rsp=0, sub_rdt and sub_err hold their last value.
- Response order equals request order. No response is dropped or duplicated.
- Write responses also pulse sub_rsp; sub_rdt is don't-care for them but is still sampled.
- Reset mid-operation discards all queued requests and in-flight responses. No sub_rsp is emitted for them.

Optional Feature:
- Macro: TCB_LIB_REGISTER_BACKPRESSURE_FIFO_BYPASS_EN.
- When defined: if count==0, sub_vld=1 and man_rdy=1, the request passes straight through combinationally to the man_* outputs. It is popped in the same cycle (0-cycle request latency) and not written into the FIFO. sub_rdy stays registered.
- When undefined: no bypass; minimum request latency is 1 cycle.

Test Plan:
- Reset: hold rst=0 for 2 clk, with sub_vld=1 driven during reset -> sub_rdy=0, man_vld=0 and sub_rsp=0 throughout; sub_rdy=1 on the first edge after release.
- Write then read (DEPTH=2, DLY=1, man_rdy=1):
  - write adr=0x10, wdt=0x01234567, ben=0xF at cycle t -> man_vld with the same payload at t+1, sub_rsp at t+3.
  - read of 0x10 -> sub_rdt=0x01234567, sub_err=0.
- Full stall (DEPTH=2): man_rdy=0 and 3 back-to-back pushes -> 2 accepted, then sub_rdy=0. Raise man_rdy -> heads drain in order 0x10, 0x14; the third request is accepted only after sub_rdy rises again.
- Streaming (DEPTH=2, DLY=0): 8 reads with man_rdy=1 -> one man_vld transfer per cycle and 8 sub_rsp pulses in order. Toggle man_rdy 1/0 -> order is preserved and no response is lost.
- Error and DEPTH=1: man_err=1 on the 2nd of 3 requests -> only the 2nd sub_rsp carries sub_err=1. With DEPTH=1, sub_rdy alternates 1,0,1.
- Mid-flight reset: assert rst with 2 entries queued and 1 response in flight -> no further sub_rsp and man_vld=0 immediately. With the bypass macro, an empty FIFO plus man_rdy=1 gives man_vld in the same cycle as the sub handshake.

Source files
------------

// File: rtl/tcb_lib_register_backpressure_fifo.sv
// TCB register slice: DEPTH-entry request FIFO with registered sub_rdy and in-order response return.
// Optional same-cycle bypass when empty: define TCB_LIB_REGISTER_BACKPRESSURE_FIFO_BYPASS_EN.
module tcb_lib_register_backpressure_fifo #(
   parameter int unsigned DLY   = 1,
   parameter int unsigned ADR   = 32,
   parameter int unsigned DAT   = 32,
   parameter int unsigned DEPTH = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             sub_vld,
   output logic             sub_rdy,
   input  logic             sub_wen,
   input  logic [ADR-1:0]   sub_adr,
   input  logic [DAT/8-1:0] sub_ben,
   input  logic [DAT-1:0]   sub_wdt,
   output logic             sub_rsp,
   output logic [DAT-1:0]   sub_rdt,
   output logic             sub_err,
   output logic             man_vld,
   input  logic             man_rdy,
   output logic             man_wen,
   output logic [ADR-1:0]   man_adr,
   output logic [DAT/8-1:0] man_ben,
   output logic [DAT-1:0]   man_wdt,
   input  logic [DAT-1:0]   man_rdt,
   input  logic             man_err
);
   localparam int unsigned BEN   = DAT/8;
   localparam int unsigned CW    = $clog2(DEPTH+1);
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SLOTS = 1 << PW;

   typedef struct packed {
      logic           wen;
      logic [ADR-1:0] adr;
      logic [BEN-1:0] ben;
      logic [DAT-1:0] wdt;
   } req_t;

   // Storage is rounded up to a power of two so the pointer width matches the index;
   // pointers still wrap at DEPTH-1, so the extra slots are never touched.
   req_t          mem_q [SLOTS];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sub_rdy_q, sub_rdy_d;
   logic          sub_rsp_q, sub_rsp_d;
   logic          sub_err_q, sub_err_d;
   logic [DAT-1:0] sub_rdt_q, sub_rdt_d;
   logic          push, pop, byp, fifo_wr, fifo_rd;
   req_t          sub_req, man_req;
   logic [DLY:0]  vld_pipe;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign sub_req = {sub_wen, sub_adr, sub_ben, sub_wdt};

`ifdef TCB_LIB_REGISTER_BACKPRESSURE_FIFO_BYPASS_EN
   assign byp = (cnt_q == '0) & sub_vld & sub_rdy_q & man_rdy;
`else
   assign byp = 1'b0;
`endif

   assign push    = sub_vld & sub_rdy_q;
   assign man_vld = (cnt_q != '0) | byp;
   assign pop     = man_vld & man_rdy;
   assign fifo_wr = push & ~byp;
   assign fifo_rd = pop & ~byp;
   assign man_req = byp ? sub_req : mem_q[rd_ptr_q];

   assign man_wen = man_req.wen;
   assign man_adr = man_req.adr;
   assign man_ben = man_req.ben;
   assign man_wdt = man_req.wdt;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (fifo_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (fifo_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (fifo_wr & ~fifo_rd)      cnt_d = cnt_q + 1'b1;
      else if (~fifo_wr & fifo_rd) cnt_d = cnt_q - 1'b1;
      // No pop lookahead: ready only depends on the next occupancy.
      sub_rdy_d = (cnt_d < CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         sub_rdy_q <= 1'b0;
      end else begin
         if (fifo_wr) mem_q[wr_ptr_q] <= sub_req;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         sub_rdy_q <= sub_rdy_d;
      end
   end

   assign sub_rdy = sub_rdy_q;

   // vld_pipe[k] marks a man-side pop k cycles ago; man_rdt is sampled at stage DLY.
   generate
      if (DLY > 0) begin : g_dly
         logic [DLY-1:0] dly_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) dly_q <= '0;
            else      dly_q <= vld_pipe[DLY-1:0];
         end
         assign vld_pipe = {dly_q, pop};
      end else begin : g_nodly
         assign vld_pipe = pop;
      end
   endgenerate

   always_comb begin
      sub_rsp_d = vld_pipe[DLY];
      sub_rdt_d = sub_rdt_q;
      sub_err_d = sub_err_q;
      if (vld_pipe[DLY]) begin
         sub_rdt_d = man_rdt;
         sub_err_d = man_err;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sub_rsp_q <= 1'b0;
         sub_rdt_q <= '0;
         sub_err_q <= 1'b0;
      end else begin
         sub_rsp_q <= sub_rsp_d;
         sub_rdt_q <= sub_rdt_d;
         sub_err_q <= sub_err_d;
      end
   end

   assign sub_rsp = sub_rsp_q;
   assign sub_rdt = sub_rdt_q;
   assign sub_err = sub_err_q;

endmodule

// File: tb/tb_tcb_lib_register_backpressure_fifo.sv
// Bench for tcb_lib_register_backpressure_fifo: DEPTH=2/DLY=1 main instance plus a DEPTH=1/DLY=0 instance.
module tb_tcb_lib_register_backpressure_fifo;
`ifdef TCB_LIB_REGISTER_BACKPRESSURE_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   logic        sub_vld = 1'b0, sub_wen = 1'b0;
   logic [31:0] sub_adr = '0, sub_wdt = '0;
   logic [3:0]  sub_ben = '0;
   logic        sub_rdy, sub_rsp, sub_err;
   logic [31:0] sub_rdt;
   logic        man_vld, man_wen;
   logic [31:0] man_adr, man_wdt;
   logic [3:0]  man_ben;
   logic        man_rdy = 1'b0, man_err = 1'b0;
   logic [31:0] man_rdt = '0;

   logic        d_sub_vld = 1'b0, d_sub_wen = 1'b0;
   logic [31:0] d_sub_adr = '0, d_sub_wdt = '0;
   logic [3:0]  d_sub_ben = 4'hF;
   logic        d_sub_rdy, d_sub_rsp, d_sub_err;
   logic [31:0] d_sub_rdt;
   logic        d_man_vld, d_man_wen;
   logic [31:0] d_man_adr, d_man_wdt, d_man_rdt;
   logic [3:0]  d_man_ben;
   logic        d_man_rdy = 1'b1, d_man_err = 1'b0;
   assign d_man_rdt = 32'hA5A5_0000 | d_man_adr;

   tcb_lib_register_backpressure_fifo #(.DLY(1), .ADR(32), .DAT(32), .DEPTH(2)) u_dut (
      .clk(clk), .rst(rst),
      .sub_vld(sub_vld), .sub_rdy(sub_rdy), .sub_wen(sub_wen), .sub_adr(sub_adr),
      .sub_ben(sub_ben), .sub_wdt(sub_wdt), .sub_rsp(sub_rsp), .sub_rdt(sub_rdt), .sub_err(sub_err),
      .man_vld(man_vld), .man_rdy(man_rdy), .man_wen(man_wen), .man_adr(man_adr),
      .man_ben(man_ben), .man_wdt(man_wdt), .man_rdt(man_rdt), .man_err(man_err));

   tcb_lib_register_backpressure_fifo #(.DLY(0), .ADR(32), .DAT(32), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst),
      .sub_vld(d_sub_vld), .sub_rdy(d_sub_rdy), .sub_wen(d_sub_wen), .sub_adr(d_sub_adr),
      .sub_ben(d_sub_ben), .sub_wdt(d_sub_wdt), .sub_rsp(d_sub_rsp), .sub_rdt(d_sub_rdt), .sub_err(d_sub_err),
      .man_vld(d_man_vld), .man_rdy(d_man_rdy), .man_wen(d_man_wen), .man_adr(d_man_adr),
      .man_ben(d_man_ben), .man_wdt(d_man_wdt), .man_rdt(d_man_rdt), .man_err(d_man_err));

   int n_run = 0, n_fail = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Downstream memory: one-cycle response after each handshake; unwritten reads return ~adr.
   logic [31:0] ram [logic [31:0]];
   always @(posedge clk) begin
      if (man_vld && man_rdy) begin
         if (man_wen) begin
            ram[man_adr] = man_wdt;
            man_rdt <= 32'hDEAD_BEEF;
         end else begin
            man_rdt <= ram.exists(man_adr) ? ram[man_adr] : ~man_adr;
         end
         man_err <= (man_adr == 32'h0000_BAD0);
      end
   end

   typedef struct {logic chk; logic [31:0] rdt; logic err;} exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      exp_t e;
      if (rst && sub_rsp === 1'b1) begin
         if (sb.size() == 0) begin
            n_run++; n_fail++;
            $display("FAIL rsp_unexpected: got sub_rsp=1 rdt=%h want no response", sub_rdt);
         end else begin
            e = sb.pop_front();
            if (e.chk) check("rsp_rdt", sub_rdt, e.rdt);
            check("rsp_err", {31'd0, sub_err}, {31'd0, e.err});
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge with sub_vld still high.
   task automatic send(input logic wen, input logic [31:0] adr, input logic [31:0] wdt,
                       input logic chk, input logic [31:0] rdt, input logic err, input logic tog);
      int k;
      k = 0;
      sub_vld = 1'b1; sub_wen = wen; sub_adr = adr; sub_wdt = wdt; sub_ben = 4'hF;
      while (!sub_rdy && k < 20) begin
         @(negedge clk);
         if (tog) man_rdy = ~man_rdy;
         k++;
      end
      if (!sub_rdy) begin
         n_run++; n_fail++;
         $display("FAIL send_timeout: adr=%h not accepted within 20 cycles", adr);
      end else begin
         sb.push_back('{chk, rdt, err});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {logic wen; logic [31:0] adr; logic [31:0] wdt; logic chk; logic [31:0] rdt; logic err;} vec_t;
   vec_t tbl[8];

   int lat, c0;
   logic [31:0] cap_adr, cap_wdt;
   logic cap_wen;

   initial begin
      tbl[0] = '{1'b1, 32'h20,   32'hAAAA_0001, 1'b0, 32'h0,          1'b0};
      tbl[1] = '{1'b1, 32'h24,   32'hAAAA_0002, 1'b0, 32'h0,          1'b0};
      tbl[2] = '{1'b0, 32'h20,   32'h0,         1'b1, 32'hAAAA_0001,  1'b0};
      tbl[3] = '{1'b0, 32'hBAD0, 32'h0,         1'b1, 32'hFFFF_452F,  1'b1};
      tbl[4] = '{1'b0, 32'h24,   32'h0,         1'b1, 32'hAAAA_0002,  1'b0};
      tbl[5] = '{1'b0, 32'h10,   32'h0,         1'b1, 32'h0123_4567,  1'b0};
      tbl[6] = '{1'b0, 32'h30,   32'h0,         1'b1, 32'hFFFF_FFCF,  1'b0};
      tbl[7] = '{1'b0, 32'h20,   32'h0,         1'b1, 32'hAAAA_0001,  1'b0};

      // Reset held with a request pending and downstream ready.
      sub_vld = 1'b1; man_rdy = 1'b1; sub_adr = 32'h44;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_sub_rdy", {31'd0, sub_rdy}, 32'd0);
         check("rst_man_vld", {31'd0, man_vld}, 32'd0);
         check("rst_sub_rsp", {31'd0, sub_rsp}, 32'd0);
         check("rst_man_adr", man_adr, 32'd0);
         check("rst_sub_rdt", sub_rdt, 32'd0);
      end
      rst = 1'b1; sub_vld = 1'b0;
      #1 check("rel_sub_rdy_low", {31'd0, sub_rdy}, 32'd0);
      @(negedge clk);
      check("rel_sub_rdy", {31'd0, sub_rdy}, 32'd1);
      check("rel_d1_sub_rdy", {31'd0, d_sub_rdy}, 32'd1);

      // Write 0x10 with latency tracking.
      lat = -1;
      sub_vld = 1'b1; sub_wen = 1'b1; sub_adr = 32'h10; sub_wdt = 32'h0123_4567; sub_ben = 4'hF;
      check("w_sub_rdy", {31'd0, sub_rdy}, 32'd1);
      sb.push_back('{1'b0, 32'h0, 1'b0});
      if (man_vld) begin lat = 0; cap_adr = man_adr; cap_wdt = man_wdt; cap_wen = man_wen; end
      @(negedge clk);
      if (lat < 0 && man_vld) begin lat = 1; cap_adr = man_adr; cap_wdt = man_wdt; cap_wen = man_wen; end
      check("w_man_ben", {28'd0, man_ben}, BYP ? 32'h0 : 32'hF);
      sub_vld = 1'b0;
      check("w_latency", lat, BYP ? 32'd0 : 32'd1);
      check("w_man_adr", cap_adr, 32'h10);
      check("w_man_wdt", cap_wdt, 32'h0123_4567);
      check("w_man_wen", {31'd0, cap_wen}, 32'd1);
      check("w_rsp_t1", {31'd0, sub_rsp}, 32'd0);
      @(negedge clk);
      check("w_rsp_t2", {31'd0, sub_rsp}, {31'd0, BYP});
      @(negedge clk);
      check("w_rsp_t3", {31'd0, sub_rsp}, {31'd0, !BYP});

      send(1'b0, 32'h10, 32'h0, 1'b1, 32'h0123_4567, 1'b0, 1'b0);
      sub_vld = 1'b0;
      repeat (4) @(negedge clk);

      // Full stall: two accepted, third waits for sub_rdy.
      man_rdy = 1'b0;
      send(1'b0, 32'h10, 32'h0, 1'b1, 32'h0123_4567, 1'b0, 1'b0);
      send(1'b0, 32'h14, 32'h0, 1'b1, 32'hFFFF_FFEB, 1'b0, 1'b0);
      sub_wen = 1'b1; sub_adr = 32'h18; sub_wdt = 32'h55AA_55AA;
      check("stall_rdy0", {31'd0, sub_rdy}, 32'd0);
      check("stall_head0", man_adr, 32'h10);
      @(negedge clk);
      check("stall_rdy1", {31'd0, sub_rdy}, 32'd0);
      check("stall_head1", man_adr, 32'h10);
      man_rdy = 1'b1;
      @(negedge clk);
      check("drain_head", man_adr, 32'h14);
      check("drain_rdy", {31'd0, sub_rdy}, 32'd1);
      send(1'b1, 32'h18, 32'h55AA_55AA, 1'b0, 32'h0, 1'b0, 1'b0);
      sub_vld = 1'b0;
      repeat (4) @(negedge clk);

      // Streaming at full rate, then with man_rdy toggling.
      man_rdy = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 8; i++)
         send(tbl[i].wen, tbl[i].adr, tbl[i].wdt, tbl[i].chk, tbl[i].rdt, tbl[i].err, 1'b0);
      check("stream_cycles", cyc - c0, 32'd8);
      sub_vld = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         man_rdy = ~man_rdy;
         send(tbl[i].wen, tbl[i].adr, tbl[i].wdt, tbl[i].chk, tbl[i].rdt, tbl[i].err, 1'b1);
      end
      sub_vld = 1'b0; man_rdy = 1'b1;
      repeat (6) @(negedge clk);
      check("drain_sb_empty", sb.size(), 32'd0);

      // DEPTH=1, DLY=0 instance with continuous requests.
      d_sub_vld = 1'b1; d_sub_adr = 32'h100;
      check("d1_rdy0", {31'd0, d_sub_rdy}, 32'd1);
      @(negedge clk);
      check("d1_rdy1", {31'd0, d_sub_rdy}, {31'd0, BYP});
      check("d1_rsp1", {31'd0, d_sub_rsp}, {31'd0, BYP});
      d_sub_adr = 32'h104;
      @(negedge clk);
      check("d1_rdy2", {31'd0, d_sub_rdy}, 32'd1);
      check("d1_rsp2", {31'd0, d_sub_rsp}, 32'd1);
      check("d1_rdt2", d_sub_rdt, BYP ? 32'hA5A5_0104 : 32'hA5A5_0100);
      d_sub_vld = 1'b0;

      // Mid-flight reset with work queued and a response in flight.
      repeat (4) @(negedge clk);
      man_rdy = 1'b1;
      send(1'b0, 32'h20, 32'h0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
      send(1'b0, 32'h24, 32'h0, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
      sub_vld = 1'b0; man_rdy = 1'b0;
      #2 rst = 1'b0;
      sb.delete();
      #1;
      check("mrst_man_vld", {31'd0, man_vld}, 32'd0);
      check("mrst_sub_rsp", {31'd0, sub_rsp}, 32'd0);
      check("mrst_sub_rdy", {31'd0, sub_rdy}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("mrst_hold_rsp", {31'd0, sub_rsp}, 32'd0);
      end
      rst = 1'b1; man_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_man_vld", {31'd0, man_vld}, 32'd0);
         check("post_rst_rsp", {31'd0, sub_rsp}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end
endmodule
